adc_i2c_target: RTL and testbench
=================================

Name: adc_i2c_target

Overview:
- I2C target (responder) that emulates the board ADC. It answers the read/write transactions issued by the adc_control I2C master on the same scl/sda pair.
- Used in system simulation and on-board loopback testing, so the oscilloscope chain (adc_control, trigger, display) can run without the physical converter.
- Returns a 12-bit sample supplied by a stimulus source (for example a waveform generator) in the converter's 2-byte read format.
- Accepts a 1-byte configuration write that selects the reported channel.

Parameters:
- DEV_ADDR, 7'h28: 7-bit I2C target address.
- SYNC_STAGES, 2: synchronizer flops on scl_in and sda_in (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the SCL frequency.
- rst  in  1  reset, synchronous, active-high.
- scl_in  in  1  SCL line level (asynchronous).
- sda_in  in  1  SDA line level (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release (open-drain, external pull-up).
- sample_data  in  12  sample value to return; sampled only at the latch point.
- cfg_channel  out  2  channel selected by the last configuration write.
- rd_latch  out  1  1-cycle pulse when sample_data is captured.
- wr_strobe  out  1  1-cycle pulse when a configuration byte is accepted.
- busy  out  1  high from an address match until STOP or the return to IDLE.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high.
- Reset values: sda_oe=0, cfg_channel=0, rd_latch=0, wr_strobe=0, busy=0, FSM=IDLE. The synchronizers reset to 1 (idle bus).
- Synchronization: scl and sda pass through SYNC_STAGES flops, then a 1-flop edge detector.
- Bus conditions:
  - START = synced sda falls while synced scl is high.
  - STOP = synced sda rises while synced scl is high.
- Bit timing:
  - Data is sampled on the synced SCL rising edge.
  - The target changes sda_oe on the cycle after a synced SCL falling edge.
  - sda_oe never changes while synced scl is high.
- Byte format: MSB first, 3-bit bit counter, 8-bit shift register.
- FSM states and transitions:
  - IDLE: on START go to ADDR.
  - ADDR: shift 8 bits. If addr==DEV_ADDR, go to ADDR_ACK and set busy=1; otherwise go to WAIT_STOP with no ACK.
  - ADDR_ACK: drive sda_oe=1 for the 9th clock, release on the following SCL fall.
    - R/W=1: latch {cfg_channel, sample_data} at this ACK, pulse rd_latch, go to RD_DATA with byte index 0.
    - R/W=0: go to WR_DATA.
  - RD_DATA: drive the bits of the current byte.
    - Byte0 = {2'b00, cfg_channel, data[11:8]}; byte1 = data[7:0].
    - sda_oe = ~bit.
    - After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's ACK on SCL rise.
    - ACK (0) after byte0: go to RD_DATA byte1.
    - ACK (0) after byte1: re-latch sample_data, pulse rd_latch, go to RD_DATA byte0 (continuous streaming).
    - NACK (1): go to WAIT_STOP.
  - WR_DATA: shift 8 bits, then cfg_channel <= byte[1:0], pulse wr_strobe, go to WR_ACK.
  - WR_ACK: drive ACK, then return to WR_DATA. Multiple bytes are allowed; the last byte wins.
  - WAIT_STOP: sda_oe=0; wait for STOP or START.
- STOP in any state: go to IDLE, sda_oe=0, busy=0 on the next cycle.
- Repeated START in any state: go to ADDR, sda_oe=0, bit counter cleared. busy stays high only if the new address matches.
- An aborted byte (STOP or START mid-byte) does not update cfg_channel or pulse wr_strobe.
- START and STOP cannot coincide (both need a sda edge). An SCL edge and a START/STOP detected in the same cycle resolve to START/STOP.
- Reset mid-transfer: SDA is released immediately on the reset cycle. Transactions in progress are abandoned; the target then waits for a fresh START.
- rd_latch and wr_strobe are 1 cycle wide and never asserted in the same cycle.

Test Plan:
- Read, sample_data=12'hA5C, cfg_channel=0, master reads 2 bytes and NACKs: master receives 8'h0A, 8'h5C; one rd_latch pulse; busy drops 1 cycle after STOP detection.
- Write 8'h03 to address 0x28, then read with sample_data=12'h123: cfg_channel=3 after wr_strobe; read returns 8'h31, 8'h23.
- Address 0x29: no ACK (sda_oe stays 0 for the whole transaction), busy=0, no strobes, next START to 0x28 works normally.
- Streaming read of 4 bytes (ACK, ACK, ACK, NACK), sample_data changing 12'h001 then 12'h002: bytes 0x00,0x01,0x00,0x02; two rd_latch pulses.
- Write with STOP after 4 bits: cfg_channel unchanged, no wr_strobe, FSM in IDLE. Repeated START after the address ACK of a write, then a read, is handled correctly.
- Reset asserted while the target drives a 0 data bit: sda_oe=0 on the cycle after reset is sampled; outputs at reset values; the following full read is correct.

Source files
------------

// File: rtl/adc_i2c_target.sv
// rtl/adc_i2c_target.sv - I2C target emulating the board ADC sample read and channel config write
module adc_i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h28,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [11:0] sample_data,
  output logic [1:0]  cfg_channel,
  output logic        rd_latch,
  output logic        wr_strobe,
  output logic        busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_RD_DATA   = 3'd3;
  localparam logic [2:0] S_RD_ACK    = 3'd4;
  localparam logic [2:0] S_WR_DATA   = 3'd5;
  localparam logic [2:0] S_WR_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  // Fewer than two flops would not protect against metastability.
  localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NSYNC-1:0] r_scl_sync;
  logic [NSYNC-1:0] r_sda_sync;
  logic             r_scl_d;
  logic             r_sda_d;

  logic [2:0]  r_state;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_shift;
  logic        r_rw;
  logic        r_ack_phase;
  logic        r_byte_idx;
  logic [13:0] r_rd_word;
  logic        r_sda_oe;
  logic [1:0]  r_cfg_channel;
  logic        r_rd_latch;
  logic        r_wr_strobe;
  logic        r_busy;

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_rd_byte0;
  logic [7:0] w_new_byte0;

  assign w_scl      = r_scl_sync[NSYNC-1];
  assign w_sda      = r_sda_sync[NSYNC-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high on both sides of the SDA edge, so an SCL/SDA pair
  // changing together (e.g. right after reset) is never mistaken for START/STOP.
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  // First byte of a read word: channel tag plus the sample's upper nibble.
  assign w_rd_byte0  = {2'b00, r_rd_word[13:12], r_rd_word[11:8]};
  assign w_new_byte0 = {2'b00, r_cfg_channel, sample_data[11:8]};

  // Bring the bus lines into the clk domain and keep one delayed copy for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[NSYNC-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[NSYNC-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  // Protocol FSM: bus conditions override any SCL edge seen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 7'd0;
      r_rw          <= 1'b0;
      r_ack_phase   <= 1'b0;
      r_byte_idx    <= 1'b0;
      r_rd_word     <= 14'd0;
      r_sda_oe      <= 1'b0;
      r_cfg_channel <= 2'd0;
      r_rd_latch    <= 1'b0;
      r_wr_strobe   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rd_latch  <= 1'b0;
      r_wr_strobe <= 1'b0;
      if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= 3'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sda_oe <= 1'b0;
          end
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[5:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_rw        <= w_sda;
                r_ack_phase <= 1'b0;
                if (r_shift == DEV_ADDR) begin
                  r_state <= S_ADDR_ACK;
                  r_busy  <= 1'b1;
                end else begin
                  r_state <= S_WAIT_STOP;
                  r_busy  <= 1'b0;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                // Start of the ACK clock: pull SDA and, for reads, freeze the word.
                r_ack_phase <= 1'b1;
                r_sda_oe    <= 1'b1;
                if (r_rw) begin
                  r_rd_word  <= {r_cfg_channel, sample_data};
                  r_rd_latch <= 1'b1;
                end
              end else begin
                r_ack_phase <= 1'b0;
                r_bit_cnt   <= 3'd0;
                if (r_rw) begin
                  r_state    <= S_RD_DATA;
                  r_byte_idx <= 1'b0;
                  r_shift    <= w_rd_byte0[6:0];
                  r_sda_oe   <= ~w_rd_byte0[7];
                end else begin
                  r_state  <= S_WR_DATA;
                  r_sda_oe <= 1'b0;
                end
              end
            end
          end
          S_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd7) begin
                r_state   <= S_RD_ACK;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 3'd0;
              end else begin
                r_sda_oe  <= ~r_shift[6];
                r_shift   <= {r_shift[5:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise && w_sda) begin
              r_state <= S_WAIT_STOP;
            end else if (w_scl_fall) begin
              r_state <= S_RD_DATA;
              if (!r_byte_idx) begin
                r_byte_idx <= 1'b1;
                r_shift    <= r_rd_word[6:0];
                r_sda_oe   <= ~r_rd_word[7];
              end else begin
                // Master wants more: stream a freshly captured sample.
                r_byte_idx <= 1'b0;
                r_rd_word  <= {r_cfg_channel, sample_data};
                r_rd_latch <= 1'b1;
                r_shift    <= w_new_byte0[6:0];
                r_sda_oe   <= ~w_new_byte0[7];
              end
            end
          end
          S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[5:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_cfg_channel <= {r_shift[0], w_sda};
                r_wr_strobe   <= 1'b1;
                r_ack_phase   <= 1'b0;
                r_state       <= S_WR_ACK;
              end
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_ack_phase <= 1'b1;
                r_sda_oe    <= 1'b1;
              end else begin
                r_ack_phase <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_bit_cnt   <= 3'd0;
                r_state     <= S_WR_DATA;
              end
            end
          end
          default: begin
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // Reset releases SDA in the same cycle rather than one clock later.
  assign sda_oe      = r_sda_oe & ~rst;
  assign cfg_channel = r_cfg_channel;
  assign rd_latch    = r_rd_latch;
  assign wr_strobe   = r_wr_strobe;
  assign busy        = r_busy;

endmodule

// File: tb/tb_adc_i2c_target.sv
// tb/tb_adc_i2c_target.sv - randomized I2C master bench for adc_i2c_target with a transaction-level model
module tb_adc_i2c_target;

  localparam int         Q   = 5;
  localparam logic [6:0] DEV = 7'h28;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [11:0] sample_data = 12'd0;
  logic        sda_oe;
  logic [1:0]  cfg_channel;
  logic        rd_latch;
  logic        wr_strobe;
  logic        busy;
  wire         sda_line;

  assign sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  adc_i2c_target #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (m_scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .sample_data(sample_data),
    .cfg_channel(cfg_channel),
    .rd_latch   (rd_latch),
    .wr_strobe  (wr_strobe),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;
  int n_rd  = 0;
  int n_wr  = 0;

  // Transaction-level model state.
  logic [1:0]  m_cfg  = 2'd0;
  logic        m_busy = 1'b0;
  int          exp_rd = 0;
  int          exp_wr = 0;
  logic [11:0] words[4];
  logic [7:0]  rd_got[8];

  logic       mon_en      = 1'b0;
  logic       allow_drive = 1'b1;
  logic       prev_oe     = 1'b0;
  logic [1:0] prev_cfg    = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare: pulse exclusivity, SDA only moves with SCL low,
  // silence when not addressed, channel changes only with its strobe.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (rd_latch) n_rd++;
      if (wr_strobe) n_wr++;
      check("pulse_excl", 32'(rd_latch & wr_strobe), 32'd0);
      if (sda_oe !== prev_oe) check("oe_scl_low", 32'(m_scl), 32'd0);
      if (!allow_drive) check("oe_silent", 32'(sda_oe), 32'd0);
      if (cfg_channel !== prev_cfg) check("cfg_with_strobe", 32'(wr_strobe), 32'd1);
    end
    prev_oe  <= sda_oe;
    prev_cfg <= cfg_channel;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start;
    m_sda = 1'b1; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    m_sda = 1'b0; wait_q(1);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic bus_stop;
    m_sda = 1'b0; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    check("busy_before_stop", 32'(busy), 32'(m_busy));
    m_sda = 1'b1; wait_q(2);
    check("busy_after_stop", 32'(busy), 32'd0);
    m_busy = 1'b0;
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_q(1);
    m_scl = 1'b1; wait_q(2);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    b = sda_line; wait_q(1);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack_bit);
    logic [7:0] v;
    logic       x;
    v = 8'd0;
    for (int i = 0; i < 8; i++) begin
      read_bit(x);
      v = {v[6:0], x};
    end
    write_bit(ack_bit);
    d = v;
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw, output logic ack);
    write_byte({a, rw}, ack);
    check("addr_ack", 32'(ack), (a == DEV) ? 32'd0 : 32'd1);
    m_busy = (a == DEV);
    if (a == DEV && rw) exp_rd++;
  endtask

  task automatic write_body(input logic [6:0] a, input int n, input logic [7:0] first);
    logic       ack;
    logic [7:0] d;
    send_addr(a, 1'b0, ack);
    if (a == DEV) begin
      for (int i = 0; i < n; i++) begin
        d = (i == 0) ? first : 8'($urandom);
        write_byte(d, ack);
        check("wr_ack", 32'(ack), 32'd0);
        m_cfg = d[1:0];
        exp_wr++;
      end
    end
  endtask

  task automatic read_body(input logic [6:0] a, input int n);
    logic       ack;
    logic [7:0] b;
    logic [7:0] e;
    sample_data = words[0];
    send_addr(a, 1'b1, ack);
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 1) sample_data = words[i/2 + 1];
      read_byte(b, (i == n - 1));
      rd_got[i] = b;
      if (a != DEV) e = 8'hFF;
      else if (i % 2 == 0) e = {2'b00, m_cfg, words[i/2][11:8]};
      else e = words[i/2][7:0];
      check("rd_byte", 32'(b), 32'(e));
      if (a == DEV && i % 2 == 1 && i < n - 1) exp_rd++;
    end
  endtask

  task automatic txn_end;
    check("rd_latch_count", 32'(n_rd), 32'(exp_rd));
    check("wr_strobe_count", 32'(n_wr), 32'(exp_wr));
    check("cfg_channel", 32'(cfg_channel), 32'(m_cfg));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda_oe"}, 32'(sda_oe), 32'd0);
    check({tag, "_cfg"}, 32'(cfg_channel), 32'd0);
    check({tag, "_rd_latch"}, 32'(rd_latch), 32'd0);
    check({tag, "_wr_strobe"}, 32'(wr_strobe), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  logic       ack;
  logic [6:0] ra;
  int         kind;

  initial begin
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    mon_en = 1'b1;
    wait_q(2);

    // Plain 2-byte read.
    words[0] = 12'hA5C;
    bus_start; read_body(DEV, 2); bus_stop; txn_end;
    check("t1_b0", 32'(rd_got[0]), 32'h0A);
    check("t1_b1", 32'(rd_got[1]), 32'h5C);
    check("t1_latches", 32'(n_rd), 32'd1);

    // Channel write then read back.
    bus_start; write_body(DEV, 1, 8'h03); bus_stop; txn_end;
    check("t2_cfg", 32'(cfg_channel), 32'd3);
    check("t2_strobes", 32'(n_wr), 32'd1);
    words[0] = 12'h123;
    bus_start; read_body(DEV, 2); bus_stop; txn_end;
    check("t2_b0", 32'(rd_got[0]), 32'h31);
    check("t2_b1", 32'(rd_got[1]), 32'h23);

    // Foreign address: no ACK, no drive, then a normal read.
    allow_drive = 1'b0;
    bus_start; read_body(7'h29, 1); bus_stop;
    allow_drive = 1'b1;
    txn_end;
    check("t3_busy", 32'(busy), 32'd0);
    words[0] = 12'h7E1;
    bus_start; read_body(DEV, 2); bus_stop; txn_end;
    check("t3_b0", 32'(rd_got[0]), 32'h37);
    check("t3_b1", 32'(rd_got[1]), 32'hE1);
    check("t3_latches", 32'(n_rd), 32'd3);

    // Streaming read across two samples.
    bus_start; write_body(DEV, 1, 8'h00); bus_stop; txn_end;
    words[0] = 12'h001; words[1] = 12'h002;
    bus_start; read_body(DEV, 4); bus_stop; txn_end;
    check("t4_b0", 32'(rd_got[0]), 32'h00);
    check("t4_b1", 32'(rd_got[1]), 32'h01);
    check("t4_b2", 32'(rd_got[2]), 32'h00);
    check("t4_b3", 32'(rd_got[3]), 32'h02);
    check("t4_latches", 32'(n_rd), 32'd5);

    // Write aborted after 4 bits, then repeated START into a read.
    bus_start; send_addr(DEV, 1'b0, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    bus_stop; txn_end;
    check("t5_cfg", 32'(cfg_channel), 32'd0);
    check("t5_strobes", 32'(n_wr), 32'd2);
    words[0] = 12'h9AB;
    bus_start; send_addr(DEV, 1'b0, ack);
    bus_start; read_body(DEV, 2); bus_stop; txn_end;
    check("t5_b0", 32'(rd_got[0]), 32'h09);
    check("t5_b1", 32'(rd_got[1]), 32'hAB);

    // Reset while the target pulls SDA for a 0 data bit.
    bus_start; write_body(DEV, 1, 8'h02); bus_stop; txn_end;
    words[0] = 12'h456;
    sample_data = words[0];
    bus_start; send_addr(DEV, 1'b1, ack);
    repeat (2) @(negedge clk);
    check("t6_oe_driving", 32'(sda_oe), 32'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_oe_in_reset", 32'(sda_oe), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6");
    m_cfg = 2'd0; m_busy = 1'b0;
    mon_en = 1'b1;
    bus_stop; txn_end;
    bus_start; read_body(DEV, 2); bus_stop; txn_end;
    check("t6_b0", 32'(rd_got[0]), 32'h04);
    check("t6_b1", 32'(rd_got[1]), 32'h56);

    // Random mix of transactions.
    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          bus_start; write_body(DEV, int'($urandom_range(1, 3)), 8'($urandom)); bus_stop;
        end
        1: begin
          for (int k = 0; k < 4; k++) words[k] = 12'($urandom);
          bus_start; read_body(DEV, int'($urandom_range(1, 6))); bus_stop;
        end
        2: begin
          ra = 7'($urandom);
          if (ra == DEV) ra = 7'h29;
          allow_drive = 1'b0;
          bus_start;
          if ($urandom_range(0, 1) == 0) send_addr(ra, 1'b0, ack);
          else read_body(ra, int'($urandom_range(1, 2)));
          bus_stop;
          allow_drive = 1'b1;
        end
        default: begin
          bus_start; send_addr(DEV, 1'b0, ack);
          for (int k = 0; k < int'($urandom_range(1, 7)); k++) write_bit(1'($urandom));
          bus_stop;
        end
      endcase
      txn_end;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
